lsu_axi_master: RTL and testbench

Initiator side of the NPC's AXI4-Lite-style memory interface, used by the multicycle core's load/store stage. It accepts one load or store request at a time from the core, drives the AR/R or AW/W/B channels toward a memory responder, and returns read data or completion status plus an error flag. One transaction is outstanding at most; there is no pipelining of requests.

---
 rtl/lsu_axi_pkg.sv | 19 +
 rtl/lsu_axi_master_wdog.sv | 29 ++
 rtl/lsu_axi_master.sv | 172 +++++++++++++++++
 tb/tb_lsu_axi_master.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_axi_pkg.sv
// Shared types and AXI response codes for the LSU AXI initiator.
// Holds the FSM state enum and the rresp/bresp encodings.
package lsu_axi_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_DATA,
        S_WR_REQ,
        S_WR_RESP,
        S_RESP
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/lsu_axi_master_wdog.sv
// Per-transaction watchdog: counts busy cycles and flags expiry.
// Ports: clk, rst (sync, active-high), clear, en -> expired.
module axi_wdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + CW'(1);
        end
    end

    // Flag during the last allowed busy cycle so the FSM leaves
    // after exactly TIMEOUT_CYCLES cycles of waiting.
    assign expired = en && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/lsu_axi_master.sv
// Single-outstanding AXI4-Lite initiator for the load/store stage.
// Core side: req_* / resp_*; bus side: AR, R, AW, W, B channels.
// Optional watchdog enabled by defining LSU_TIMEOUT_EN.
module lsu_axi_master
    import lsu_axi_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [7:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        aw_done;
    logic        w_done;
    logic        accept;
    logic        aw_hs;
    logic        w_hs;
    logic        busy;
    logic        to_fire;

    assign accept = (state == S_IDLE) && req_valid;
    assign aw_hs  = (state == S_WR_REQ) && !aw_done && awready;
    assign w_hs   = (state == S_WR_REQ) && !w_done && wready;
    assign busy   = (state == S_RD_ADDR) || (state == S_RD_DATA) ||
                    (state == S_WR_REQ)  || (state == S_WR_RESP);

`ifdef LSU_TIMEOUT_EN
    logic expired;

    axi_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == S_IDLE),
        .en     (busy),
        .expired(expired)
    );

    // A handshake completing in the expiry cycle wins; only a
    // stalled state is aborted.
    assign to_fire = expired && (state_nxt == state);
`else
    assign to_fire = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else if (to_fire) begin
            state <= S_RESP;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (req_valid) begin
                    state_nxt = req_wen ? S_WR_REQ : S_RD_ADDR;
                end
            end
            S_RD_ADDR: begin
                if (arready) state_nxt = S_RD_DATA;
            end
            S_RD_DATA: begin
                if (rvalid) state_nxt = S_RESP;
            end
            S_WR_REQ: begin
                if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                    state_nxt = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (bvalid) state_nxt = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request latch, write handshake tracking, response capture
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wstrb_q <= req_wstrb;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
            if (to_fire) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end else if (state == S_RD_DATA && rvalid) begin
                rdata_q <= rdata;
                err_q   <= (rresp != RESP_OKAY);
            end else if (state == S_WR_RESP && bvalid) begin
                rdata_q <= '0;
                err_q   <= (bresp != RESP_OKAY);
            end
        end
    end

    // Outputs are pure functions of registered state
    always_comb begin
        req_ready  = (state == S_IDLE);
        resp_valid = (state == S_RESP);
        arvalid    = (state == S_RD_ADDR);
        rready     = (state == S_RD_DATA);
        awvalid    = (state == S_WR_REQ) && !aw_done;
        wvalid     = (state == S_WR_REQ) && !w_done;
        bready     = (state == S_WR_RESP);
        araddr     = addr_q;
        awaddr     = addr_q;
        wdata      = wdata_q;
        wstrb      = {4'b0000, wstrb_q};
        resp_rdata = rdata_q;
        resp_err   = err_q;
    end

endmodule

// File: tb/tb_lsu_axi_master.sv
// Directed self-checking bench for lsu_axi_master.
// Bench plays core and memory responder by hand.
module tb_lsu_axi_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [31:0] wdata;
    logic [7:0]  wstrb;
    logic        wvalid;
    logic        wready = 1'b0;
    logic [1:0]  bresp = '0;
    logic        bvalid = 1'b0;
    logic        bready;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lsu_axi_master #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_wen(req_wen), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid),
        .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid),
        .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".req_ready"},  32'(req_ready),  32'd1);
        chk({tag, ".resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, ".resp_rdata"}, resp_rdata,      32'd0);
        chk({tag, ".resp_err"},   32'(resp_err),   32'd0);
        chk({tag, ".valids"},
            {28'd0, arvalid, awvalid, wvalid, rready | bready}, 32'd0);
        chk({tag, ".araddr"}, araddr, 32'd0);
        chk({tag, ".awaddr"}, awaddr, 32'd0);
        chk({tag, ".wdata"},  wdata,  32'd0);
        chk({tag, ".wstrb"},  32'(wstrb), 32'd0);
    endtask

    initial begin
        // Reset
        tick();
        tick();
        chk_reset_outputs("rst0");
        rst = 1'b0;

        // Load, zero-wait responder
        req_valid = 1'b1; req_wen = 1'b0;
        req_addr = 32'h8000_0000; arready = 1'b1;
        tick();                               // edge N accepts
        req_valid = 1'b0;
        chk("ld.arvalid", 32'(arvalid), 32'd1);
        chk("ld.araddr", araddr, 32'h8000_0000);
        chk("ld.req_ready", 32'(req_ready), 32'd0);
        tick();                               // N+1: AR handshake
        arready = 1'b0;
        chk("ld.rready", 32'(rready), 32'd1);
        chk("ld.arvalid_lo", 32'(arvalid), 32'd0);
        rvalid = 1'b1; rdata = 32'h0000_0413; rresp = 2'b00;
        tick();                               // N+2: R handshake
        rvalid = 1'b0;
        chk("ld.resp_valid", 32'(resp_valid), 32'd1);
        chk("ld.rdata", resp_rdata, 32'h0000_0413);
        chk("ld.err", 32'(resp_err), 32'd0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("ld.idle", 32'(req_ready), 32'd1);
        chk("ld.resp_lo", 32'(resp_valid), 32'd0);

        // Store, AW accepted two cycles before W
        req_valid = 1'b1; req_wen = 1'b1;
        req_addr = 32'h8000_0010; req_wdata = 32'hDEAD_BEEF;
        req_wstrb = 4'b0011;
        tick();
        req_valid = 1'b0;
        chk("st.awvalid", 32'(awvalid), 32'd1);
        chk("st.wvalid", 32'(wvalid), 32'd1);
        chk("st.awaddr", awaddr, 32'h8000_0010);
        chk("st.wdata", wdata, 32'hDEAD_BEEF);
        chk("st.wstrb", 32'(wstrb), 32'h03);
        awready = 1'b1;
        tick();                               // AW handshake
        awready = 1'b0;
        chk("st.aw_drop", 32'(awvalid), 32'd0);
        chk("st.w_hold1", 32'(wvalid), 32'd1);
        tick();
        chk("st.w_hold2", 32'(wvalid), 32'd1);
        chk("st.bready_lo", 32'(bready), 32'd0);
        wready = 1'b1;
        tick();                               // W handshake
        wready = 1'b0;
        chk("st.w_drop", 32'(wvalid), 32'd0);
        chk("st.bready", 32'(bready), 32'd1);
        bvalid = 1'b1; bresp = 2'b00;
        tick();
        bvalid = 1'b0;
        chk("st.resp_valid", 32'(resp_valid), 32'd1);
        chk("st.err", 32'(resp_err), 32'd0);
        chk("st.rdata", resp_rdata, 32'd0);
        chk("st.bready_off", 32'(bready), 32'd0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // Load with AR stalled three cycles, SLVERR
        req_valid = 1'b1; req_wen = 1'b0;
        req_addr = 32'h8000_0040;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall.arvalid", 32'(arvalid), 32'd1);
            chk("stall.araddr", araddr, 32'h8000_0040);
            tick();
        end
        chk("stall.arvalid3", 32'(arvalid), 32'd1);
        chk("stall.araddr3", araddr, 32'h8000_0040);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'h0000_1234; rresp = 2'b10;
        tick();
        rvalid = 1'b0; rresp = 2'b00;
        chk("stall.err", 32'(resp_err), 32'd1);
        chk("stall.rdata", resp_rdata, 32'h0000_1234);

        // Response back-pressure with a new request pending
        req_valid = 1'b1; req_wen = 1'b1;
        req_addr = 32'h8000_0020; req_wdata = 32'h1122_3344;
        req_wstrb = 4'hF;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp.resp_valid", 32'(resp_valid), 32'd1);
            chk("bp.rdata", resp_rdata, 32'h0000_1234);
            chk("bp.err", 32'(resp_err), 32'd1);
            chk("bp.req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("bp.idle", 32'(req_ready), 32'd1);
        tick();                               // pending store accepted
        req_valid = 1'b0;
        chk("bp.awvalid", 32'(awvalid), 32'd1);
        chk("bp.awaddr", awaddr, 32'h8000_0020);
        chk("bp.wstrb", 32'(wstrb), 32'h0F);
        awready = 1'b1; wready = 1'b1;
        tick();                               // AW and W together
        awready = 1'b0; wready = 1'b0;
        chk("bp.bready", 32'(bready), 32'd1);

        // Reset in WR_RESP
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_outputs("rst1");

        // Normal load after reset
        req_valid = 1'b1; req_wen = 1'b0;
        req_addr = 32'h8000_0100; arready = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("post.araddr", araddr, 32'h8000_0100);
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'hCAFE_F00D;
        tick();
        rvalid = 1'b0;
        chk("post.resp_valid", 32'(resp_valid), 32'd1);
        chk("post.rdata", resp_rdata, 32'hCAFE_F00D);
        chk("post.err", 32'(resp_err), 32'd0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

`ifdef LSU_TIMEOUT_EN
        // Watchdog: AR never accepted
        begin
            int waited;
            waited = 0;
            req_valid = 1'b1; req_wen = 1'b0;
            req_addr = 32'h8000_0200;
            tick();
            req_valid = 1'b0;
            while (!resp_valid && waited < 40) begin
                tick();
                waited++;
            end
            chk("to.cycles", 32'(waited), 32'd16);
            chk("to.arvalid", 32'(arvalid), 32'd0);
            chk("to.err", 32'(resp_err), 32'd1);
            chk("to.rdata", resp_rdata, 32'd0);
            resp_ready = 1'b1;
            tick();
            resp_ready = 1'b0;
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
